// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the sequenced ALU: MIPS funct codes, the controller
// state enum, and a helper that classifies a funct code as legal for a build.
// -----------------------------------------------------------------------------
package alu_pkg;

  localparam logic [5:0] F_AND   = 6'b100100;
  localparam logic [5:0] F_OR    = 6'b100101;
  localparam logic [5:0] F_ADD   = 6'b100000;
  localparam logic [5:0] F_SUB   = 6'b100010;
  localparam logic [5:0] F_SLT   = 6'b101010;
  localparam logic [5:0] F_SRL   = 6'b000010;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MFLO  = 6'b010010;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Multiply-related codes only exist when the multiplier is built in.
  function automatic logic funct_legal(input logic [5:0] f, input logic mul_en);
    case (f)
      F_AND, F_OR, F_ADD, F_SUB, F_SLT, F_SRL: return 1'b1;
      F_MULTU, F_MFHI, F_MFLO:                 return mul_en;
      default:                                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mul_seq_shiftadd.sv
// -----------------------------------------------------------------------------
// mul_seq_shiftadd
// Iterative unsigned shift-add multiplier, one step per clock.
// Ports:
//   clk          clock
//   reset        synchronous active-low reset
//   i_load       capture multiplicand/multiplier, clear accumulator, count=0
//   i_step       perform one shift-add step
//   i_mcand      multiplicand (A)
//   i_mplier     multiplier (B)
//   o_prod_next  product value after the step currently being taken
//   o_last       current step is the final (WIDTH-th) step
// -----------------------------------------------------------------------------
module mul_seq_shiftadd #(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_load,
  input  logic               i_step,
  input  logic [WIDTH-1:0]   i_mcand,
  input  logic [WIDTH-1:0]   i_mplier,
  output logic [2*WIDTH-1:0] o_prod_next,
  output logic               o_last
);

  localparam int CW = $clog2(WIDTH);

  logic [2*WIDTH-1:0] r_prod;
  logic [WIDTH-1:0]   r_mcand;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH:0]     w_sum;

  // Multiplier lives in the low half and is consumed LSB-first as the
  // product shifts right; the carry out of the upper-half add re-enters at
  // the top on the shift.
  always_comb begin
    w_sum       = {1'b0, r_prod[2*WIDTH-1:WIDTH]} +
                  (r_prod[0] ? {1'b0, r_mcand} : '0);
    o_prod_next = {w_sum, r_prod[WIDTH-1:1]};
    o_last      = (r_cnt == CW'(WIDTH - 1));
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prod  <= '0;
      r_mcand <= '0;
      r_cnt   <= '0;
    end else if (i_load) begin
      r_prod  <= {{WIDTH{1'b0}}, i_mplier};
      r_mcand <= i_mcand;
      r_cnt   <= '0;
    end else if (i_step) begin
      r_prod  <= o_prod_next;
      r_cnt   <= r_cnt + CW'(1);
    end
  end

endmodule

// File: rtl/alu_seq_unit.sv
// -----------------------------------------------------------------------------
// alu_seq_unit
// Registered, start/done handshaked ALU decoded by MIPS funct codes, with an
// optional iterative MULTU into internal HI/LO (read back via MFHI/MFLO).
// Ports:
//   clk      clock
//   reset    synchronous active-low reset
//   start    launch an operation (only looked at while idle)
//   Signal   funct code
//   dataA    operand A (rs)
//   dataB    operand B (rt); SRL shift amount in its low log2(WIDTH) bits
//   dataOut  registered result, held until the next done
//   busy     high while a multiply is iterating
//   done     one-cycle pulse, dataOut/err valid
//   err      with done: illegal funct code (dataOut=0)
//
// state  | meaning
// S_IDLE | waiting for start
// S_MUL  | multiplier stepping, busy=1
// S_DONE | result valid, done=1 for one cycle
// -----------------------------------------------------------------------------
module alu_seq_unit
  import alu_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter bit MUL_EN = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [5:0]       Signal,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  output logic [WIDTH-1:0] dataOut,
  output logic             busy,
  output logic             done,
  output logic             err
);

  localparam int SHW = $clog2(WIDTH);

  state_t             r_state;
  state_t             w_state_next;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic [WIDTH-1:0]   r_dout;
  logic               r_err;
  logic [WIDTH-1:0]   w_alu;
  logic               w_legal;
  logic               w_is_mul;
  logic               w_launch;
  logic               w_step;
  logic               w_last;
  logic [2*WIDTH-1:0] w_prod_next;

  assign w_legal  = funct_legal(Signal, MUL_EN);
  assign w_is_mul = w_legal && (Signal == F_MULTU);
  assign w_launch = (r_state == S_IDLE) && start;
  assign w_step   = (r_state == S_MUL);

  mul_seq_shiftadd #(.WIDTH(WIDTH)) u_mul (
    .clk         (clk),
    .reset       (reset),
    .i_load      (w_launch && w_is_mul),
    .i_step      (w_step),
    .i_mcand     (dataA),
    .i_mplier    (dataB),
    .o_prod_next (w_prod_next),
    .o_last      (w_last)
  );

  always_comb begin
    w_alu = '0;
    case (Signal)
      F_AND:  w_alu = dataA & dataB;
      F_OR:   w_alu = dataA | dataB;
      F_ADD:  w_alu = dataA + dataB;
      F_SUB:  w_alu = dataA - dataB;
      F_SLT:  w_alu = {{(WIDTH-1){1'b0}}, ($signed(dataA) < $signed(dataB))};
      F_SRL:  w_alu = dataA >> dataB[SHW-1:0];
      F_MFHI: w_alu = r_hi;
      F_MFLO: w_alu = r_lo;
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy         = 1'b0;
    done         = 1'b0;
    case (r_state)
      S_IDLE: if (start) w_state_next = w_is_mul ? S_MUL : S_DONE;
      S_MUL: begin
        busy = 1'b1;
        if (w_last) w_state_next = S_DONE;
      end
      S_DONE: begin
        done         = 1'b1;
        w_state_next = S_IDLE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_hi   <= '0;
      r_lo   <= '0;
      r_dout <= '0;
      r_err  <= 1'b0;
    end else begin
      if (w_launch) begin
        r_err <= !w_legal;
        if (!w_is_mul) r_dout <= w_legal ? w_alu : '0;
      end
      if (w_step && w_last) begin
        r_hi   <= w_prod_next[2*WIDTH-1:WIDTH];
        r_lo   <= w_prod_next[WIDTH-1:0];
        r_dout <= w_prod_next[WIDTH-1:0];
      end
    end
  end

  assign dataOut = r_dout;
  assign err     = r_err & done;

endmodule

// File: tb/tb_alu_seq_unit.sv
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [5:0]  Signal;
  logic [31:0] dataA, dataB;
  logic [31:0] dataOut, dataOut0;
  logic        busy, done, err, busy0, done0, err0;

  int tests = 0;
  int fails = 0;

  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  alu_seq_unit #(.WIDTH(32), .MUL_EN(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start), .Signal(Signal),
    .dataA(dataA), .dataB(dataB), .dataOut(dataOut),
    .busy(busy), .done(done), .err(err)
  );

  alu_seq_unit #(.WIDTH(32), .MUL_EN(1'b0)) dut0 (
    .clk(clk), .reset(reset), .start(start), .Signal(Signal),
    .dataA(dataA), .dataB(dataB), .dataOut(dataOut0),
    .busy(busy0), .done(done0), .err(err0)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference behaviour from the instruction definitions; updates the
  // modelled HI/LO only for a multiplier-equipped build.
  function automatic void model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                                input bit mul_en, output logic [31:0] res, output logic e,
                                output int lat);
    longint unsigned p;
    res = 32'h0; e = 1'b0; lat = 1;
    case (f)
      6'b100100: res = a & b;
      6'b100101: res = a | b;
      6'b100000: res = a + b;
      6'b100010: res = a - b;
      6'b101010: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      6'b000010: res = a >> (b % 32);
      6'b011001: if (mul_en) begin
        p = longint'(a) * longint'(b);
        m_hi = p[63:32]; m_lo = p[31:0]; res = m_lo; lat = 33;
      end else e = 1'b1;
      6'b010000: if (mul_en) res = m_hi; else e = 1'b1;
      6'b010010: if (mul_en) res = m_lo; else e = 1'b1;
      default:   e = 1'b1;
    endcase
  endfunction

  task automatic do_op(input string tag, input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input bit poke);
    logic [31:0] er, er0, dout, d0_out;
    logic        ee, ee0, e, d0_done, d0_err, busy_ok;
    int          el, el0, lat;
    model(f, a, b, 1'b1, er, ee, el);
    model(f, a, b, 1'b0, er0, ee0, el0);
    @(negedge clk);
    start = 1'b1; Signal = f; dataA = a; dataB = b;
    @(negedge clk);
    lat = 1;
    d0_done = done0; d0_out = dataOut0; d0_err = err0;
    start = 1'b0;
    dataA = $urandom; dataB = $urandom; Signal = 6'($urandom);
    busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 100) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (poke) begin
        start = 1'($urandom_range(0, 1));
        Signal = 6'($urandom); dataA = $urandom; dataB = $urandom;
      end
      @(negedge clk);
      lat++;
    end
    start = 1'b0;
    dout = dataOut; e = err;
    chk({tag, " latency"}, lat, el);
    chk({tag, " dataOut"}, dout, er);
    chk({tag, " err"}, e, ee);
    chk({tag, " busy_during"}, busy_ok, 1'b1);
    chk({tag, " busy_at_done"}, busy, 1'b0);
    if (!poke) begin
      chk({tag, " nomul done"}, d0_done, 1'b1);
      chk({tag, " nomul dataOut"}, d0_out, er0);
      chk({tag, " nomul err"}, d0_err, ee0);
    end
  endtask

  logic [5:0] pool [9] = '{6'b100100, 6'b100101, 6'b100000, 6'b100010, 6'b101010,
                           6'b000010, 6'b011001, 6'b010000, 6'b010010};

  initial begin
    reset = 1'b0; start = 1'b0; Signal = 6'h0; dataA = 32'h0; dataB = 32'h0;
    m_hi = 32'h0; m_lo = 32'h0;
    repeat (3) @(negedge clk);
    chk("rst dataOut", dataOut, 32'h0);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);
    chk("rst err", err, 1'b0);
    reset = 1'b1;

    do_op("and", 6'b100100, 32'hF, 32'h5, 1'b0);
    do_op("or", 6'b100101, 32'hA, 32'h5, 1'b0);
    do_op("add", 6'b100000, 32'hA, 32'h5, 1'b0);
    do_op("sub", 6'b100010, 32'hF, 32'h5, 1'b0);
    do_op("sub_wrap", 6'b100010, 32'h0, 32'h1, 1'b0);
    do_op("slt_pos", 6'b101010, 32'h3, 32'h1, 1'b0);
    do_op("slt_neg", 6'b101010, 32'hFFFFFFFF, 32'h1, 1'b0);
    do_op("srl31", 6'b000010, 32'h80000000, 32'd31, 1'b0);
    do_op("srl32", 6'b000010, 32'h80000000, 32'h20, 1'b0);
    do_op("multu", 6'b011001, 32'hFFFFFFFF, 32'h2, 1'b1);
    do_op("mfhi", 6'b010000, 32'h0, 32'h0, 1'b0);
    do_op("mflo", 6'b010010, 32'h0, 32'h0, 1'b0);
    do_op("illegal", 6'b111111, 32'h1234, 32'h5678, 1'b0);

    // Abort a multiply with reset partway through.
    @(negedge clk);
    start = 1'b1; Signal = 6'b011001; dataA = 32'h12345; dataB = 32'h6789;
    @(negedge clk);
    start = 1'b0;
    repeat (9) @(negedge clk);
    chk("pre_abort busy", busy, 1'b1);
    reset = 1'b0;
    @(negedge clk);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort dataOut", dataOut, 32'h0);
    reset = 1'b1;
    m_hi = 32'h0; m_lo = 32'h0;
    @(negedge clk);
    chk("post_abort done", done, 1'b0);
    do_op("mfhi_after_abort", 6'b010000, 32'h0, 32'h0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      logic [5:0]  f;
      logic [31:0] a, b;
      f = ($urandom_range(0, 5) == 0) ? 6'($urandom) : pool[$urandom_range(0, 8)];
      a = $urandom; b = $urandom;
      if ($urandom_range(0, 3) == 0) a = {$urandom_range(0, 1) ? 16'hFFFF : 16'h0, 16'($urandom)};
      do_op("rand", f, a, b, 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
